// File: rtl/enc_binder_bank_if.sv
// Request/response bundle for enc_binder_bank.
//   start_encoding : job request, sampled only while the bank is idle
//   unbind         : 0 = rotate left (bind), 1 = rotate right (unbind); sampled with start
//   level_hv       : NUM_CH input hypervectors, sampled with start
//   shifted_hv     : NUM_CH registered rotated hypervectors
//   busy           : high while a job is in progress
//   done           : one-cycle pulse, every shifted_hv entry is valid from this cycle
// master = the requester (level-HV lookup side), slave = the binder bank.
interface enc_binder_bank_if #(
  parameter int unsigned HV_DIM = 1024,
  parameter int unsigned NUM_CH = 10
);
  logic                               start_encoding;
  logic                               unbind;
  logic [0:NUM_CH-1][HV_DIM-1:0]      level_hv;
  logic [0:NUM_CH-1][HV_DIM-1:0]      shifted_hv;
  logic                               busy;
  logic                               done;

  modport master (
    output start_encoding,
    output unbind,
    output level_hv,
    input  shifted_hv,
    input  busy,
    input  done
  );

  modport slave (
    input  start_encoding,
    input  unbind,
    input  level_hv,
    output shifted_hv,
    output busy,
    output done
  );
endinterface

// File: rtl/enc_binder_bank.sv
// Time-multiplexed hypervector binder bank.
// On an accepted start the NUM_CH level hypervectors and the unbind mode are snapshotted.
// The snapshot is then rotated, LANES channels per cycle, by each channel's fixed shift,
// over G = ceil(NUM_CH/LANES) cycles. done pulses once the last group has been written.
// Ports:
//   clk  : clock, rising edge
//   nrst : asynchronous active-low reset
//   bus  : enc_binder_bank_if slave modport (start/unbind/level_hv in, shifted_hv/busy/done out)
// SHIFTS: per-channel rotation amount, reduced mod HV_DIM. An all-ones entry (the default)
// selects the stock amount 7*i+1 for channel i.
module enc_binder_bank #(
  parameter int unsigned             HV_DIM = 1024,
  parameter int unsigned             NUM_CH = 10,
  parameter int unsigned             LANES  = 2,
  parameter logic [0:NUM_CH-1][31:0] SHIFTS = '1
) (
  input  logic             clk,
  input  logic             nrst,
  enc_binder_bank_if.slave bus
);

  localparam int unsigned G  = (NUM_CH + LANES - 1) / LANES;
  localparam int unsigned GW = (G + 1 > 1) ? $clog2(G + 1) : 1;
  localparam int unsigned SW = (HV_DIM > 1) ? $clog2(HV_DIM) : 1;
  localparam int unsigned CW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  typedef enum logic [0:0] {StIdle, StRun} state_e;

  state_e                         state_q;
  logic [GW-1:0]                  grp_q;
  logic                           busy_q;
  logic                           done_q;
  logic                           unbind_q;
  logic [0:NUM_CH-1][HV_DIM-1:0]  snap_q;
  logic [0:NUM_CH-1][HV_DIM-1:0]  shifted_q;

  logic [31:0]                    lane_ch  [LANES];
  logic [HV_DIM-1:0]              lane_out [LANES];

  function automatic logic [SW-1:0] eff_shift(logic [CW-1:0] idx);
    logic [31:0] raw;
    if (SHIFTS[idx] == '1) raw = 7 * 32'(idx) + 1;
    else                   raw = SHIFTS[idx];
    return SW'(raw % HV_DIM);
  endfunction

  // Rotation on a doubled vector: the wrapped-around bits come from the second copy.
  function automatic logic [HV_DIM-1:0] rotate(logic [HV_DIM-1:0] v, logic [SW-1:0] s,
                                               logic right);
    logic [2*HV_DIM-1:0] dbl;
    dbl = {v, v};
    if (right) begin
      dbl = dbl >> s;
      return dbl[HV_DIM-1:0];
    end
    dbl = dbl << s;
    return dbl[2*HV_DIM-1:HV_DIM];
  endfunction

  // One rotator per lane; lanes past the last channel produce zero and are never written.
  always_comb begin
    for (int unsigned l = 0; l < LANES; l++) begin
      lane_ch[l]  = 32'(grp_q) * LANES + l;
      lane_out[l] = '0;
      if (lane_ch[l] < NUM_CH) begin
        lane_out[l] = rotate(snap_q[CW'(lane_ch[l])], eff_shift(CW'(lane_ch[l])), unbind_q);
      end
    end
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q  <= StIdle;
      grp_q    <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      unbind_q <= 1'b0;
      snap_q   <= '0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (bus.start_encoding) begin
            snap_q   <= bus.level_hv;
            unbind_q <= bus.unbind;
            grp_q    <= '0;
            busy_q   <= 1'b1;
            state_q  <= StRun;
          end
        end
        StRun: begin
          grp_q <= grp_q + 1'b1;
          if (grp_q == GW'(G - 1)) begin
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  // Channel c is owned by lane c % LANES of group c / LANES; other entries hold.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      shifted_q <= '0;
    end else if (state_q == StRun) begin
      for (int unsigned c = 0; c < NUM_CH; c++) begin
        if (32'(grp_q) == c / LANES) shifted_q[c] <= lane_out[c % LANES];
      end
    end
  end

  assign bus.shifted_hv = shifted_q;
  assign bus.busy       = busy_q;
  assign bus.done       = done_q;

endmodule

// File: tb/tb_enc_binder_bank.sv
module tb_enc_binder_bank;
  localparam int unsigned HV = 16;
  localparam int unsigned NC = 5;
  localparam logic [0:NC-1][31:0] Shifts = {32'd0, 32'd1, 32'd4, 32'd15, 32'd17};

  typedef logic [0:NC-1][HV-1:0] hv_arr_t;

  // Hand-computed vectors.
  localparam hv_arr_t LvOne   = {16'h0001, 16'h0001, 16'h0001, 16'h0001, 16'h0001};
  localparam hv_arr_t ExpBind = {16'h0001, 16'h0002, 16'h0010, 16'h8000, 16'h0002};
  localparam hv_arr_t Lv8001  = {16'h8001, 16'h8001, 16'h8001, 16'h8001, 16'h8001};
  localparam hv_arr_t ExpUnb  = {16'h8001, 16'hC000, 16'h1800, 16'h0003, 16'hC000};
  localparam hv_arr_t LvF0    = {16'h00F0, 16'h00F0, 16'h00F0, 16'h00F0, 16'h00F0};
  localparam hv_arr_t ExpF0   = {16'h00F0, 16'h01E0, 16'h0F00, 16'h0078, 16'h01E0};
  localparam hv_arr_t LvFF    = {16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF};

  logic clk = 1'b0;
  logic nrst;
  always #5 clk = ~clk;

  enc_binder_bank_if #(.HV_DIM(HV), .NUM_CH(NC)) bus_a ();
  enc_binder_bank_if #(.HV_DIM(HV), .NUM_CH(NC)) bus_b ();

  enc_binder_bank #(.HV_DIM(HV), .NUM_CH(NC), .LANES(2), .SHIFTS(Shifts)) dut_a (
    .clk  (clk),
    .nrst (nrst),
    .bus  (bus_a)
  );

  enc_binder_bank #(.HV_DIM(HV), .NUM_CH(NC), .LANES(5), .SHIFTS(Shifts)) dut_b (
    .clk  (clk),
    .nrst (nrst),
    .bus  (bus_b)
  );

  int checks = 0;
  int errors = 0;
  hv_arr_t exp_a[$];
  hv_arr_t exp_b[$];

  task automatic chk(string name, logic [127:0] act, logic [127:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard monitors: compare on every done pulse against the oldest pushed expectation.
  initial begin
    hv_arr_t e;
    forever begin
      tick();
      if (bus_a.done) begin
        if (exp_a.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL a_unexpected_done actual=1 required=0");
        end else begin
          e = exp_a.pop_front();
          for (int c = 0; c < NC; c++) chk($sformatf("a_result_ch%0d", c), bus_a.shifted_hv[c], e[c]);
        end
      end
    end
  end

  initial begin
    hv_arr_t e;
    forever begin
      tick();
      if (bus_b.done) begin
        if (exp_b.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL b_unexpected_done actual=1 required=0");
        end else begin
          e = exp_b.pop_front();
          for (int c = 0; c < NC; c++) chk($sformatf("b_result_ch%0d", c), bus_b.shifted_hv[c], e[c]);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  // Drives a start request that is accepted at the next edge (E0); returns just after E0.
  task automatic launch_a(hv_arr_t lv, logic ub, hv_arr_t e);
    bus_a.level_hv       = lv;
    bus_a.unbind         = ub;
    bus_a.start_encoding = 1'b1;
    exp_a.push_back(e);
    tick();
    bus_a.start_encoding = 1'b0;
  endtask

  initial begin
    nrst                 = 1'b0;
    bus_a.start_encoding = 1'b0;
    bus_a.unbind         = 1'b0;
    bus_a.level_hv       = '0;
    bus_b.start_encoding = 1'b0;
    bus_b.unbind         = 1'b0;
    bus_b.level_hv       = '0;
    tick();
    tick();
    nrst = 1'b1;

    // Reset then idle.
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("idle_busy_done", {bus_a.busy, bus_a.done}, 2'b00);
      chk("idle_shifted", bus_a.shifted_hv, '0);
    end

    // Bind job: group-by-group visibility.
    launch_a(LvOne, 1'b0, ExpBind);
    chk("bind_e0_busy", bus_a.busy, 1'b1);
    chk("bind_e0_ch0", bus_a.shifted_hv[0], 16'h0000);
    tick();
    chk("bind_e1_ch0", bus_a.shifted_hv[0], 16'h0001);
    chk("bind_e1_ch1", bus_a.shifted_hv[1], 16'h0002);
    chk("bind_e1_ch2", bus_a.shifted_hv[2], 16'h0000);
    chk("bind_e1_busy_done", {bus_a.busy, bus_a.done}, 2'b10);
    tick();
    chk("bind_e2_ch2", bus_a.shifted_hv[2], 16'h0010);
    chk("bind_e2_ch3", bus_a.shifted_hv[3], 16'h8000);
    chk("bind_e2_ch4", bus_a.shifted_hv[4], 16'h0000);
    chk("bind_e2_busy_done", {bus_a.busy, bus_a.done}, 2'b10);
    tick();
    chk("bind_e3_ch4", bus_a.shifted_hv[4], 16'h0002);
    chk("bind_e3_busy_done", {bus_a.busy, bus_a.done}, 2'b01);
    tick();
    chk("bind_e4_busy_done", {bus_a.busy, bus_a.done}, 2'b00);

    // Unbind job.
    launch_a(Lv8001, 1'b1, ExpUnb);
    tick();
    tick();
    tick();
    chk("unbind_e3_done", bus_a.done, 1'b1);
    tick();

    // Starts while busy are ignored; input changes after acceptance have no effect.
    launch_a(LvOne, 1'b0, ExpBind);
    bus_a.level_hv       = LvFF;
    bus_a.unbind         = 1'b1;
    bus_a.start_encoding = 1'b1;
    tick();
    tick();
    bus_a.start_encoding = 1'b0;
    tick();
    chk("ignore_e3_done", bus_a.done, 1'b1);
    launch_a(LvF0, 1'b0, ExpF0);
    chk("reaccept_e4_busy", bus_a.busy, 1'b1);
    tick();
    tick();
    tick();
    chk("reaccept_done", bus_a.done, 1'b1);
    chk("reaccept_ch3", bus_a.shifted_hv[3], 16'h0078);
    tick();

    // Asynchronous reset mid-job.
    launch_a(Lv8001, 1'b1, ExpUnb);
    tick();
    tick();
    nrst = 1'b0;
    #1;
    exp_a.delete();
    chk("midrst_busy_done", {bus_a.busy, bus_a.done}, 2'b00);
    chk("midrst_shifted", bus_a.shifted_hv, '0);
    tick();
    nrst = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("postrst_no_done", {bus_a.busy, bus_a.done}, 2'b00);
    end
    launch_a(Lv8001, 1'b1, ExpUnb);
    tick();
    tick();
    tick();
    chk("fresh_done", bus_a.done, 1'b1);
    chk("fresh_ch2", bus_a.shifted_hv[2], 16'h1800);
    tick();

    // Single-group bank: everything written at E0+1 alongside done.
    bus_b.level_hv       = LvOne;
    bus_b.unbind         = 1'b0;
    bus_b.start_encoding = 1'b1;
    exp_b.push_back(ExpBind);
    tick();
    bus_b.start_encoding = 1'b0;
    chk("g1_e0_busy", bus_b.busy, 1'b1);
    chk("g1_e0_shifted", bus_b.shifted_hv, '0);
    tick();
    chk("g1_e1_shifted", bus_b.shifted_hv, ExpBind);
    chk("g1_e1_busy_done", {bus_b.busy, bus_b.done}, 2'b01);
    tick();
    chk("g1_e2_busy_done", {bus_b.busy, bus_b.done}, 2'b00);

    tick();
    tick();
    chk("a_pending_jobs", exp_a.size(), 0);
    chk("b_pending_jobs", exp_b.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/enc_binder_bank.md
# enc_binder_bank

Parametrised, time-multiplexed successor to the fixed ten-lane encoder binder packs. On a start pulse it snapshots NUM_CH level hypervectors and binds each one by circular rotation, using its own compile-time shift amount. It processes LANES channels per clock, so one bank replaces several hard-wired packs at a fraction of the rotator area. It also supports an unbind mode (reverse rotation) that the decode path needs. It sits between the level-HV lookup and the bundler in the sparse HDC encoder.

## Interface
- HV_DIM, 1024: hypervector width in bits.
- NUM_CH, 10: number of channels (level HVs) per job; ≥1.
- LANES, 2: physical rotators, i.e. channels processed per cycle; 1 ≤ LANES ≤ NUM_CH.
- SHIFTS, NUM_CH-entry int array, default entry i = 7*i+1: per-channel rotation amount; reduced mod HV_DIM at elaboration.
- clk  input  1  clock, rising edge.
- nrst  input  1  asynchronous, active-low reset.
- start_encoding  input  1  job request; sampled only in IDLE.
- unbind  input  1  mode, sampled with start: 0 = rotate left (bind), 1 = rotate right (unbind).
- level_hv  input  HV_DIM × [0:NUM_CH-1]  input hypervectors; sampled with start.
- shifted_hv  output  HV_DIM × [0:NUM_CH-1]  registered rotated hypervectors.
- busy  output  1  high while a job is in progress.
- done  output  1  one-cycle pulse; all shifted_hv entries are valid from this cycle.

## Operation
- G = ceil(NUM_CH/LANES) groups. Group g covers channels g*LANES … min((g+1)*LANES, NUM_CH)-1. In the last group, unused lanes write nothing.
- Rotate left by s: out[(j+s) mod HV_DIM] = in[j]. Rotate right by s: out[j] = in[(j+s) mod HV_DIM]. Shift 0 gives identity.
- FSM has two states, IDLE and RUN, plus a group counter of width $clog2(G+1).
- IDLE, start_encoding=1:
  - Snapshot level_hv and unbind into internal registers.
  - Clear grp to 0, set busy, go to RUN.
- RUN, each cycle:
  - Rotate the snapshot of each channel in group grp and write the results to shifted_hv.
  - Increment grp.
  - When writing the last group: go to IDLE, clear busy, set done.
- start_encoding while in RUN is ignored; it is not queued.
- level_hv or unbind changes after acceptance do not affect the running job.
- shifted_hv entries not in the current group hold their value. Between jobs, entries hold the previous job's results until overwritten.

## Timing
- Reset, asynchronous: state IDLE, grp=0, busy=0, done=0, all shifted_hv=0, snapshot=0. This applies mid-job as well; the job is abandoned and no done is issued.
- Edge E0, start accepted: busy=1 after E0.
- Edge E0+k, k=1..G: group k-1 is visible after that edge.
- After E0+G: busy=0 and done=1 for exactly one cycle.
- Latency from the start edge to done is G cycles.
- Earliest next accept is E0+G+1, which gives a throughput of one job per G+1 cycles.
- start_encoding held high continuously starts a new job every G+1 cycles.
- G=1 (LANES=NUM_CH): all channels are written at E0+1, and done is high in the following cycle.

## Test plan
Bench parameters: HV_DIM=16, NUM_CH=5, LANES=2 (G=3), SHIFTS={0,1,4,15,17}.
- Reset then idle: shifted_hv all 0x0000, busy=0, done=0 for 10 cycles with no start.
- Bind job, all level_hv=0x0001, unbind=0:
  - Outputs are {0x0001, 0x0002, 0x0010, 0x8000, 0x0002}.
  - Ch0–1 update at E0+1, ch2–3 at E0+2, ch4 at E0+3.
  - done pulses once after E0+3; busy is high after E0 through E0+3.
- Unbind job, level_hv=0x8001, unbind=1: outputs {0x8001, 0xC000, 0x1800, 0x0003, 0xC000}.
- Start pulsed at E0+1 and E0+2 while busy: ignored, and level_hv changed at E0+1 has no effect on results. A start at E0+4 is accepted; done pulses again 3 cycles later.
- nrst asserted at E0+2 mid-job: outputs, busy and done are 0 immediately and no done follows. A fresh job after release completes with correct values.
- Rerun the bind job with LANES=5 (G=1): all five channels update at E0+1, and done is high in the next cycle.
